baseline_subtractor: RTL and testbench

- Downstream consumer of the settle-delay stage in the electro-optical detection chain.
- Waits for the level `settle_done` signal from the settle-delay counter, then averages 2^LOG2_N detector ADC samples to estimate the noise baseline.
- After that it outputs every subsequent sample with the baseline removed, as a signed corrected value, to the noise-cancelling datapath.
- Supports on-demand recalibration.

---
 rtl/baseline_subtractor.sv | 158 +++++++++++++++
 tb/tb_baseline_subtractor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baseline_subtractor.sv
// baseline_subtractor
//   Estimates the detector noise baseline once the analog front end has
//   settled, then streams every later sample out with that baseline removed.
//
//   Flow: IDLE waits for settle_done. ACQ averages 2^LOG2_N samples into
//   `baseline`. RUN emits in_data - baseline, signed, one cycle after each
//   input sample. recal restarts acquisition. settle_done low drops the
//   block back to IDLE from any state.
//
//   Handshake: in_valid qualifies in_data for exactly the cycle it is high.
//   There is no back-pressure, so a sample can be accepted every cycle.
//   out_valid is a one-cycle strobe qualifying out_data. out_data holds
//   its value between strobes.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   settle_done    level: front end settled
//   recal          one-cycle request to re-acquire the baseline
//   in_valid       qualifies in_data
//   in_data        unsigned ADC sample [DATA_W]
//   out_valid      strobe qualifying out_data
//   out_data       signed in_data - baseline [DATA_W+1]
//   baseline       current baseline estimate [DATA_W]
//   baseline_valid baseline holds a completed estimate
//   acquiring      high while in ACQ
//   fsm_state      debug view of the FSM state (0 IDLE, 1 ACQ, 2 RUN)
module baseline_subtractor #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              settle_done,
  input  logic              recal,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W:0]   out_data,
  output logic [DATA_W-1:0] baseline,
  output logic              baseline_valid,
  output logic              acquiring,
  output logic [1:0]        fsm_state
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_COUNT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] count;
  logic [ACC_W-1:0]  acc_sum;
  logic              final_sample;

  // Sum including the current sample. It is used both to accumulate and to
  // load the baseline on the final sample.
  assign acc_sum      = acc + ACC_W'(in_data);
  assign final_sample = in_valid && (count == LAST_COUNT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Priority: settle_done low > recal > in_valid.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (settle_done) state_next = ACQ;
      end
      ACQ: begin
        if (!settle_done)      state_next = IDLE;
        else if (recal)        state_next = ACQ;
        else if (final_sample) state_next = RUN;
      end
      RUN: begin
        if (!settle_done) state_next = IDLE;
        else if (recal)   state_next = ACQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic derived from state
  always_comb begin
    acquiring = (state == ACQ);
    fsm_state = state;
  end

  // Datapath: accumulator, baseline register and corrected output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc            <= '0;
      count          <= '0;
      baseline       <= '0;
      baseline_valid <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A sample on the entry edge is deliberately not counted.
          if (settle_done) begin
            acc   <= '0;
            count <= '0;
          end
        end
        ACQ: begin
          if (!settle_done || recal) begin
            // Drop the partial sum; any sample on this edge is discarded.
            acc            <= '0;
            count          <= '0;
            baseline_valid <= 1'b0;
          end else if (in_valid) begin
            if (final_sample) begin
              baseline       <= acc_sum[ACC_W-1:LOG2_N];
              baseline_valid <= 1'b1;
              acc            <= '0;
              count          <= '0;
            end else begin
              acc   <= acc_sum;
              count <= count + 1'b1;
            end
          end
        end
        RUN: begin
          if (!settle_done || recal) begin
            // baseline keeps its old value until a new estimate loads.
            acc            <= '0;
            count          <= '0;
            baseline_valid <= 1'b0;
          end else if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= {1'b0, in_data} - {1'b0, baseline};
          end
        end
        default: begin
          acc   <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baseline_subtractor.sv
// Testbench for baseline_subtractor (DATA_W=12, LOG2_N=2).
// The reference model tracks the phase (idle / acquiring / running) and the
// list of samples gathered so far. The baseline is the integer mean of N
// samples. Every expected output is pushed into exp_q, and the monitor pops
// from it whenever out_valid is seen.
module tb_baseline_subtractor;

  localparam int DW = 12;
  localparam int L2 = 2;
  localparam int N  = 1 << L2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          settle_done = 1'b0;
  logic          recal = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW:0]   out_data;
  logic [DW-1:0] baseline;
  logic          baseline_valid;
  logic          acquiring;
  logic [1:0]    fsm_state;

  baseline_subtractor #(.DATA_W(DW), .LOG2_N(L2)) dut (
    .clk            (clk),
    .reset          (reset),
    .settle_done    (settle_done),
    .recal          (recal),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .baseline       (baseline),
    .baseline_valid (baseline_valid),
    .acquiring      (acquiring),
    .fsm_state      (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          passes = 0;
  logic [DW:0] exp_q[$];
  int          strobes = 0;
  bit          mon_en = 1'b0;

  // Reference model. Phase values: 0 idle, 1 acquiring, 2 running.
  int m_phase = 0;
  int m_samples[$];
  int m_baseline = 0;
  bit m_bvalid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_baseline = 0;
    m_bvalid   = 1'b0;
    m_samples.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input bit s, input bit r, input bit v, input int d);
    int sum;
    logic [DW:0] e;
    if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_samples.delete();
      end
    end else if (!s) begin
      m_phase  = 0;
      m_bvalid = 1'b0;
      m_samples.delete();
    end else if (r) begin
      m_phase  = 1;
      m_bvalid = 1'b0;
      m_samples.delete();
    end else if (v) begin
      if (m_phase == 1) begin
        m_samples.push_back(d);
        if (m_samples.size() == N) begin
          sum = 0;
          foreach (m_samples[i]) sum += m_samples[i];
          m_baseline = sum / N;
          m_bvalid   = 1'b1;
          m_phase    = 2;
          m_samples.delete();
        end
      end else begin
        e = (DW+1)'(d - m_baseline);
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge. The model then advances
  // on the next rising edge.
  task automatic drive(input bit s, input bit r, input bit v, input int d);
    settle_done = s;
    recal       = r;
    in_valid    = v;
    in_data     = DW'(d);
    @(posedge clk);
    model_step(s, r, v, d);
    #1;
  endtask

  task automatic sample(input int d);
    drive(1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_baseline"}, int'(baseline), 0);
    check({tag, "_baseline_valid"}, int'(baseline_valid), 0);
    check({tag, "_acquiring"}, int'(acquiring), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (out_valid) begin
        strobes++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out_valid: got out_data 0x%0h with no expected output at %0t",
                   out_data, $time);
        end else begin
          check("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end
      check("baseline_valid", int'(baseline_valid), int'(m_bvalid));
      check("acquiring", int'(acquiring), int'(m_phase == 1));
      if (m_bvalid) check("baseline", int'(baseline), m_baseline);
    end
  end

  // ---------------- stimulus ----------------
  int s0;

  initial begin
    do_reset("por");
    mon_en = 1'b1;

    // Basic baseline and subtraction
    drive(1'b1, 1'b0, 1'b1, 999);          // entry edge: sample not counted
    repeat (4) sample(100);
    check("basic_baseline", int'(baseline), 100);
    check("basic_bvalid", int'(baseline_valid), 1);
    sample(150);
    check("basic_pos", int'(out_data), 'h0032);
    sample(40);
    check("basic_neg", int'(out_data), 'h1FC4);

    // Truncation: (1+2+2+2)/4 = 1
    drive(1'b1, 1'b1, 1'b0, 0);
    sample(1); sample(2); sample(2); sample(2);
    check("trunc_baseline", int'(baseline), 1);
    sample(1);
    check("trunc_out", int'(out_data), 0);

    // Extremes
    drive(1'b1, 1'b1, 1'b0, 0);
    repeat (4) sample(4095);
    sample(0);
    check("ext_min", int'(out_data), 'h1001);
    drive(1'b1, 1'b1, 1'b0, 0);
    repeat (4) sample(0);
    sample(4095);
    check("ext_max", int'(out_data), 'h0FFF);

    // Recal in RUN together with a sample
    drive(1'b1, 1'b1, 1'b0, 0);
    repeat (4) sample(100);
    s0 = strobes;
    drive(1'b1, 1'b1, 1'b1, 500);
    check("recal_no_strobe", int'(out_valid), 0);
    check("recal_bvalid_low", int'(baseline_valid), 0);
    check("recal_baseline_held", int'(baseline), 100);
    repeat (3) sample(200);
    check("recal_bvalid_still_low", int'(baseline_valid), 0);
    sample(200);
    check("recal_new_baseline", int'(baseline), 200);
    check("recal_strobes", strobes - s0, 0);

    // settle_done drop mid-acquisition discards the partial sum
    drive(1'b1, 1'b1, 1'b0, 0);
    sample(50); sample(50);
    drive(1'b0, 1'b0, 1'b1, 50);
    check("drop_idle", int'(acquiring), 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    sample(80); sample(80);
    check("drop_no_early", int'(baseline_valid), 0);
    sample(80); sample(80);
    check("drop_baseline", int'(baseline), 80);

    // Gapped input in ACQ and RUN
    drive(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      gap(2);
      sample(30 + i);
    end
    check("gap_baseline", int'(baseline), 31);
    s0 = strobes;
    for (int i = 0; i < 5; i++) begin
      gap(2);
      sample(10 * i);
    end
    gap(1);
    check("gap_strobes", strobes - s0, 5);

    // Reset in the middle of RUN
    do_reset("midrun");
    drive(1'b1, 1'b0, 1'b1, 3000);         // entry edge again
    repeat (4) sample(9);
    check("post_reset_baseline", int'(baseline), 9);
    sample(20);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 29) == 0),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)));
    end

    gap(3);
    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
